// File: rtl/ram_dp_stream_reader.sv
// Streaming read engine for one port of a dual-port RAM: takes an (addr, len) command,
// issues reads, absorbs the one-cycle RAM latency and emits a ready/valid stream.
module ram_dp_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, READ} state_t;

  state_t                  state, state_nxt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic                    in_flight, in_flight_last;
  logic [1:0]              count;
  logic [DATA_WIDTH-1:0]   data0, data1;
  logic                    last0, last1;
  logic                    cmd_fire, pop, issue;
  logic [2:0]              occ_after;

  assign ram_we  = 1'b0;
  assign ram_din = '0;
  assign m_valid = (count != 2'd0);
  assign m_data  = data0;
  assign m_last  = last0;

  // Issue only while buffered words plus the pending read leave room for one more.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    cmd_fire  = 1'b0;
    pop       = m_valid && m_ready;
    occ_after = {1'b0, count} - {2'b00, pop} + {2'b00, in_flight};
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = cmd_valid;
        if (cmd_valid && (cmd_len != '0)) state_nxt = READ;
      end
      READ: begin
        busy  = 1'b1;
        issue = (remaining != '0) && (occ_after < 3'd2);
        if (pop && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ram_addr       <= '0;
      remaining      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      done           <= (cmd_fire && (cmd_len == '0)) || (busy && pop && m_last);
      in_flight      <= issue;
      in_flight_last <= issue && (remaining == LEN_WIDTH'(1));
      if (cmd_fire) begin
        ram_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        ram_addr  <= ram_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Two-entry FIFO; entry 0 is always the head presented on m_*.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      unique case ({in_flight, pop})
        2'b11: begin
          if (count == 2'd2) begin
            data0 <= data1;
            last0 <= last1;
            data1 <= ram_dout;
            last1 <= in_flight_last;
          end else begin
            data0 <= ram_dout;
            last0 <= in_flight_last;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= ram_dout;
            last0 <= in_flight_last;
          end else begin
            data1 <= ram_dout;
            last1 <= in_flight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_stream_reader.sv
// Bench for ram_dp_stream_reader: a queue-based model of the expected stream checked
// every cycle, plus directed scenarios pinned with hand-computed literals.
module tb_ram_dp_stream_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  ram_dp_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  bit            model_busy = 1'b0;
  bit            exp_done = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            hs_cyc = 0;
  int            done_cyc = 0;
  int            log_n = 0;
  logic [DW-1:0] log_data [256];
  logic          log_last [256];
  int            log_cyc  [256];

  // Model: a command enqueues its expected words; each handshake pops one.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_busy = 1'b0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      bit    idle_now;
      bit    nxt_done;
      word_t e;
      idle_now = !model_busy;
      nxt_done = 1'b0;
      checkOutput("ram_we", ram_we, 0);
      checkOutput("ram_din", ram_din, 0);
      checkOutput("cmd_ready", cmd_ready, idle_now);
      checkOutput("busy", busy, model_busy);
      checkOutput("done", done, exp_done);
      if (done) done_cyc = cyc;
      if (prev_stall) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, prev_data);
        checkOutput("stall_last", m_last, prev_last);
      end
      if (m_valid && exp_q.size() == 0)
        checkOutput("unexpected_valid", m_valid, 0);
      if (m_valid && m_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("stream_data", m_data, e.data);
        checkOutput("stream_last", m_last, e.last);
        if (log_n < 256) begin
          log_data[log_n] = m_data;
          log_last[log_n] = m_last;
          log_cyc[log_n]  = cyc;
          log_n++;
        end
        if (e.last) begin
          model_busy = 1'b0;
          nxt_done   = 1'b1;
        end
      end
      if (cmd_valid && idle_now) begin
        hs_cyc = cyc;
        if (cmd_len == '0) nxt_done = 1'b1;
        else begin
          model_busy = 1'b1;
          for (int i = 0; i < int'(cmd_len); i++) begin
            e.data = mem[(int'(cmd_addr) + i) % DEPTH];
            e.last = (i == int'(cmd_len) - 1);
            exp_q.push_back(e);
          end
        end
      end
      exp_done   = nxt_done;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Called at posedge+1; holds the command for exactly one cycle.
  task automatic applyStimulus(input int a, input int l);
    cmd_addr  = AW'(a);
    cmd_len   = LW'(l);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((model_busy || exp_done || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) checkOutput("wait_timeout", n, 0);
  endtask

  task automatic burstCheck(input int base);
    checkOutput("burst_count", log_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("burst_data", log_data[base+i], 105 + i);
      checkOutput("burst_cycle", log_cyc[base+i] - hs_cyc, 3 + i);
      checkOutput("burst_last", log_last[base+i], (i == 3) ? 1 : 0);
    end
    checkOutput("burst_done_cycle", done_cyc - hs_cyc, 7);
  endtask

  initial begin
    int base;
    int issued;
    int lasts;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_ram_addr", ram_addr, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single burst");
    base = log_n;
    applyStimulus(5, 4);
    waitIdle(50);
    burstCheck(base);

    $display("[TB] wrap-around");
    base = log_n;
    applyStimulus(14, 4);
    waitIdle(50);
    checkOutput("wrap_count", log_n - base, 4);
    checkOutput("wrap_d0", log_data[base+0], 114);
    checkOutput("wrap_d1", log_data[base+1], 115);
    checkOutput("wrap_d2", log_data[base+2], 100);
    checkOutput("wrap_d3", log_data[base+3], 101);
    checkOutput("wrap_no_gap", log_cyc[base+3] - log_cyc[base], 3);

    $display("[TB] backpressure");
    base = log_n;
    applyStimulus(2, 8);
    for (int n = 0; n < 400 && (model_busy || exp_done || exp_q.size() != 0); n++) begin
      issued = (int'(ram_addr) - 2 + DEPTH) % DEPTH;
      checkOutput("bp_outstanding_le2", ((issued - (log_n - base)) <= 2) ? 1 : 0, 1);
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    waitIdle(50);
    checkOutput("bp_count", log_n - base, 8);
    for (int i = 0; i < 8; i++) checkOutput("bp_data", log_data[base+i], 102 + i);

    $display("[TB] zero length then back-to-back");
    base = log_n;
    applyStimulus(9, 0);
    applyStimulus(3, 1);
    waitIdle(50);
    checkOutput("b2b_count", log_n - base, 1);
    checkOutput("b2b_data", log_data[base], 103);
    checkOutput("b2b_last", log_last[base], 1);

    $display("[TB] reset mid-burst");
    m_ready = 1'b0;
    base = log_n;
    applyStimulus(0, 8);
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("hold_ram_addr", ram_addr, 2);
    checkOutput("hold_m_valid", m_valid, 1);
    checkOutput("hold_pops", log_n - base, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mrst_m_valid", m_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_cmd_ready", cmd_ready, 1);
    checkOutput("mrst_done", done, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    base = log_n;
    applyStimulus(5, 4);
    waitIdle(50);
    burstCheck(base);

    $display("[TB] full depth");
    base = log_n;
    applyStimulus(0, DEPTH);
    waitIdle(100);
    checkOutput("full_count", log_n - base, DEPTH);
    lasts = 0;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("full_data", log_data[base+i], 100 + i);
      lasts += int'(log_last[base+i]);
    end
    checkOutput("full_last_pos", log_last[base+DEPTH-1], 1);
    checkOutput("full_last_once", lasts, 1);

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
